// File: rtl/keypad_pkg.sv
// Keypad scanner shared types, key map and defaults.
// Imported by module_keypad_scan and module_row_sync.
package keypad_pkg;

  localparam int SCAN_DIV_DEF = 27000;
  localparam int DEBOUNCE_DEF = 270000;
  localparam int REPEAT_DEF   = 13500000;

  typedef enum logic [1:0] {
    SCAN,
    DEBOUNCE,
    HOLD,
    RELEASE
  } state_e;

  typedef logic [3:0] code_t;

  // [row][col] -> key code; '*' is E, '#' is F
  localparam code_t KEY_MAP [4][4] = '{
    '{4'h1, 4'h2, 4'h3, 4'hA},
    '{4'h4, 4'h5, 4'h6, 4'hB},
    '{4'h7, 4'h8, 4'h9, 4'hC},
    '{4'hE, 4'h0, 4'hF, 4'hD}
  };

  // Index of the lowest active-low row; rows must not be all high
  function automatic logic [1:0] low_row(
    input logic [3:0] rows
  );
    logic [1:0] idx;
    idx = 2'd3;
    if (!rows[2]) idx = 2'd2;
    if (!rows[1]) idx = 2'd1;
    if (!rows[0]) idx = 2'd0;
    return idx;
  endfunction

endpackage

// File: rtl/module_row_sync.sv
// Two-flop synchroniser for the four keypad row inputs.
// Resets to all-high so an idle keypad reads as no key.
import keypad_pkg::*;

module module_row_sync (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d_i,
  output logic [3:0] q_o
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  // Double-register the asynchronous rows
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= 4'hF;
      sync_q <= 4'hF;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/module_keypad_scan.sv
// 4x4 keypad scanner: column scan, row debounce, key code + strobe.
// Optional macro KEY_REPEAT_EN adds auto-repeat strobes while held.
import keypad_pkg::*;

module module_keypad_scan #(
  parameter int SCAN_DIV        = SCAN_DIV_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
  parameter int REPEAT_CYCLES   = REPEAT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int MAX_A =
    (SCAN_DIV > DEBOUNCE_CYCLES) ?
    SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int MAXP =
    (MAX_A > REPEAT_CYCLES) ?
    MAX_A : REPEAT_CYCLES;
  localparam int CW = $clog2(MAXP) + 1;

  localparam logic [CW-1:0] SCAN_LAST =
    CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST =
    CW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    row_s;
  state_e        state_q, state_d;
  logic [1:0]    col_q, col_d;
  logic [1:0]    row_q, row_d;
  logic [CW-1:0] cnt_q, cnt_d;
  code_t         code_q, code_d;
  logic          valid_q, valid_d;
  logic          held_q, held_d;

`ifdef KEY_REPEAT_EN
  localparam logic [CW-1:0] REP_LAST =
    CW'(REPEAT_CYCLES - 1);
  logic [CW-1:0] rep_q, rep_d;
`endif

  module_row_sync u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (row_in),
    .q_o  (row_s)
  );

  // Next-state: scan dwell, debounce, hold and release tracking
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    valid_d = 1'b0;
`ifdef KEY_REPEAT_EN
    rep_d   = rep_q;
`endif
    unique case (state_q)
      SCAN: begin
        if (cnt_q == SCAN_LAST) begin
          cnt_d = '0;
          if (row_s != 4'hF) begin
            row_d   = low_row(row_s);
            state_d = DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (row_s[row_q]) begin
          state_d = SCAN;
          cnt_d   = '0;
          col_d   = col_q + 2'd1;
        end else if (cnt_q == DEB_LAST) begin
          code_d  = KEY_MAP[row_q][col_q];
          valid_d = 1'b1;
          state_d = HOLD;
          cnt_d   = '0;
`ifdef KEY_REPEAT_EN
          rep_d   = '0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (row_s[row_q]) begin
          state_d = RELEASE;
          cnt_d   = '0;
        end
`ifdef KEY_REPEAT_EN
        else if (rep_q == REP_LAST) begin
          rep_d   = '0;
          valid_d = 1'b1;
        end else begin
          rep_d = rep_q + 1'b1;
        end
`endif
      end
      RELEASE: begin
        if (row_s != 4'hF) begin
          state_d = HOLD;
`ifdef KEY_REPEAT_EN
          rep_d   = '0;
`endif
        end else if (cnt_q == DEB_LAST) begin
          state_d = SCAN;
          cnt_d   = '0;
          col_d   = col_q + 2'd1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = SCAN;
        cnt_d   = '0;
      end
    endcase
    held_d = (state_d == HOLD) ||
             (state_d == RELEASE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= SCAN;
      col_q   <= 2'd0;
      row_q   <= 2'd0;
      cnt_q   <= '0;
      code_q  <= 4'h0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

`ifdef KEY_REPEAT_EN
  // Auto-repeat period counter
  always_ff @(posedge clk) begin
    if (!rst_n) rep_q <= '0;
    else        rep_q <= rep_d;
  end
`endif

  assign col_out   = ~(4'b0001 << col_q);
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule

// File: tb/tb_module_keypad_scan.sv
// Directed bench for module_keypad_scan with a keypad matrix model.
// Small parameters: SCAN_DIV=4, DEBOUNCE_CYCLES=8, REPEAT_CYCLES=32.
module tb_module_keypad_scan;

  logic       clk;
  logic       rst_n;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [3:0][3:0] pressed;
  logic [3:0]      row_model;
  logic            rnd_en;
  logic [3:0]      rnd_rows;

  int total;
  int bad;
  int pulses;
  logic [3:0] last_code;
  logic       held_at_strobe;

  module_keypad_scan #(
    .SCAN_DIV       (4),
    .DEBOUNCE_CYCLES(8),
    .REPEAT_CYCLES  (32)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .row_in   (row_in),
    .col_out  (col_out),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A row reads low when a pressed key sits on a driven column
  always_comb begin
    for (int r = 0; r < 4; r++)
      row_model[r] = ~|(pressed[r] & ~col_out);
  end
  assign row_in = rnd_en ? rnd_rows : row_model;

  always @(posedge clk) begin
    #1;
    if (key_valid === 1'b1) begin
      pulses++;
      last_code = key_code;
      held_at_strobe = key_held;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [3:0] one;
    logic [3:0] exp;
    one = 4'b0001;
    rnd_en = 1'b1;
    rst_n = 1'b0;
    repeat (3) begin
      rnd_rows = 4'($urandom);
      @(negedge clk);
    end
    total++;
    if (col_out !== 4'b1110) begin
      bad++;
      $display("FAIL rst_col got=%b exp=1110", col_out);
    end
    total++;
    if (key_code !== 4'h0) begin
      bad++;
      $display("FAIL rst_code got=%h exp=0", key_code);
    end
    total++;
    if (key_valid !== 1'b0 || key_held !== 1'b0) begin
      bad++;
      $display("FAIL rst_flags got=%b%b exp=00",
               key_valid, key_held);
    end
    rnd_en = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k < 17; k++) begin
      exp = ~(one << ((k / 4) % 4));
      total++;
      if (col_out !== exp) begin
        bad++;
        $display("FAIL scan_seq k=%0d got=%b exp=%b",
                 k, col_out, exp);
      end
      tick(1);
    end
  endtask

  task automatic test_single_press();
    int base;
    base = pulses;
    pressed[1][1] = 1'b1;
    tick(50);
    total++;
    if (pulses - base !== 1) begin
      bad++;
      $display("FAIL press5_cnt got=%0d exp=1", pulses - base);
    end
    total++;
    if (last_code !== 4'h5) begin
      bad++;
      $display("FAIL press5_code got=%h exp=5", last_code);
    end
    total++;
    if (held_at_strobe !== 1'b1 || key_held !== 1'b1) begin
      bad++;
      $display("FAIL press5_held got=%b%b exp=11",
               held_at_strobe, key_held);
    end
    pressed[1][1] = 1'b0;
    tick(8);
    total++;
    if (key_held !== 1'b1) begin
      bad++;
      $display("FAIL rel5_held8 got=%b exp=1", key_held);
    end
    tick(4);
    total++;
    if (key_held !== 1'b0) begin
      bad++;
      $display("FAIL rel5_held12 got=%b exp=0", key_held);
    end
    tick(20);
    total++;
    if (pulses - base !== 1) begin
      bad++;
      $display("FAIL rel5_cnt got=%0d exp=1", pulses - base);
    end
  endtask

  task automatic test_short_glitch();
    int base;
    base = pulses;
    reset_dut();
    pressed[0][0] = 1'b1;
    tick(5);
    pressed[0][0] = 1'b0;
    tick(2);
    total++;
    if (col_out !== 4'b1110) begin
      bad++;
      $display("FAIL glitch_frozen got=%b exp=1110", col_out);
    end
    tick(1);
    total++;
    if (col_out !== 4'b1101) begin
      bad++;
      $display("FAIL glitch_resume got=%b exp=1101", col_out);
    end
    tick(20);
    total++;
    if (pulses - base !== 0 || key_held !== 1'b0) begin
      bad++;
      $display("FAIL glitch_pulse got=%0d/%b exp=0/0",
               pulses - base, key_held);
    end
  endtask

  task automatic test_bounce();
    int cols [3] = '{2, 0, 3};
    logic [3:0] codes [3] = '{4'hF, 4'hE, 4'hD};
    int base;
    for (int i = 0; i < 3; i++) begin
      base = pulses;
      for (int s = 0; s < 10; s++) begin
        pressed[3][cols[i]] = (s % 2 == 0);
        tick(3);
      end
      total++;
      if (pulses - base !== 0) begin
        bad++;
        $display("FAIL bounce_quiet i=%0d got=%0d exp=0",
                 i, pulses - base);
      end
      pressed[3][cols[i]] = 1'b1;
      tick(40);
      total++;
      if (pulses - base !== 1) begin
        bad++;
        $display("FAIL bounce_cnt i=%0d got=%0d exp=1",
                 i, pulses - base);
      end
      total++;
      if (last_code !== codes[i]) begin
        bad++;
        $display("FAIL bounce_code i=%0d got=%h exp=%h",
                 i, last_code, codes[i]);
      end
      pressed[3][cols[i]] = 1'b0;
      tick(30);
    end
  endtask

  task automatic test_two_keys();
    int base;
    base = pulses;
    pressed[0][0] = 1'b1;
    pressed[1][0] = 1'b1;
    tick(40);
    total++;
    if (pulses - base !== 1 || last_code !== 4'h1) begin
      bad++;
      $display("FAIL multi_first got=%0d/%h exp=1/1",
               pulses - base, last_code);
    end
    pressed[1][0] = 1'b0;
    tick(20);
    total++;
    if (pulses - base !== 1 || key_held !== 1'b1) begin
      bad++;
      $display("FAIL multi_rel1 got=%0d/%b exp=1/1",
               pulses - base, key_held);
    end
    pressed[0][0] = 1'b0;
    tick(8);
    total++;
    if (key_held !== 1'b1) begin
      bad++;
      $display("FAIL multi_held8 got=%b exp=1", key_held);
    end
    tick(4);
    total++;
    if (key_held !== 1'b0) begin
      bad++;
      $display("FAIL multi_held12 got=%b exp=0", key_held);
    end
    tick(20);
  endtask

  task automatic test_reset_mid();
    int base;
    base = pulses;
    reset_dut();
    pressed[0][1] = 1'b1;
    tick(10);
    total++;
    if (col_out !== 4'b1101) begin
      bad++;
      $display("FAIL mid_deb_col got=%b exp=1101", col_out);
    end
    rst_n = 1'b0;
    tick(1);
    total++;
    if (col_out !== 4'b1110 || key_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_rst got=%b/%b exp=1110/0",
               col_out, key_valid);
    end
    tick(8);
    total++;
    if (pulses - base !== 0 || key_held !== 1'b0) begin
      bad++;
      $display("FAIL mid_rst_pulse got=%0d/%b exp=0/0",
               pulses - base, key_held);
    end
    pressed[0][1] = 1'b0;
    rst_n = 1'b1;
    tick(10);
  endtask

  task automatic test_repeat();
    int base;
    int exp_extra;
    int n;
    bit seen;
`ifdef KEY_REPEAT_EN
    exp_extra = 3;
`else
    exp_extra = 0;
`endif
    base = pulses;
    seen = 1'b0;
    pressed[2][2] = 1'b1;
    n = 0;
    while (!seen && n < 60) begin
      tick(1);
      n++;
      if (pulses != base) seen = 1'b1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL rep_first got=timeout exp=strobe");
    end
    base = pulses;
    tick(100);
    total++;
    if (pulses - base !== exp_extra) begin
      bad++;
      $display("FAIL rep_cnt got=%0d exp=%0d",
               pulses - base, exp_extra);
    end
    total++;
    if (last_code !== 4'h9) begin
      bad++;
      $display("FAIL rep_code got=%h exp=9", last_code);
    end
    pressed[2][2] = 1'b0;
    tick(20);
    total++;
    if (key_held !== 1'b0) begin
      bad++;
      $display("FAIL rep_release got=%b exp=0", key_held);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    pulses = 0;
    last_code = 4'h0;
    held_at_strobe = 1'b0;
    pressed = '0;
    rnd_en = 1'b0;
    rnd_rows = 4'hF;
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_press();
    test_short_glitch();
    test_bounce();
    test_two_keys();
    test_reset_mid();
    test_repeat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
